// File: rtl/shreg_deser_pkg.sv
// Shared helpers for the shreg_deser serial-to-parallel stage: counter sizing,
// lane slicing and bit placement for MSB- or LSB-first collection.
package shreg_deser_pkg;

    // Bits needed to count 0..depth-1, never less than one
    function automatic int unsigned cnt_w(input int unsigned depth);
        return (depth <= 32'd1) ? 32'd1 : 32'($clog2(depth));
    endfunction

    // Low bit of lane `lane` inside the flattened output word
    function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned depth);
        return lane * depth;
    endfunction

    // Word bit that receives the idx-th serial bit of a word
    function automatic int unsigned bit_pos(input int unsigned idx, input int unsigned depth,
                                            input bit msb_first);
        return msb_first ? (depth - 32'd1 - idx) : idx;
    endfunction

endpackage

// File: rtl/shreg_deser_lane.sv
// One lane of shreg_deser: collects DEPTH serial bits and captures the word on load.
// Optional parity output under SHREG_DESER_PARITY_EN.
module shreg_deser_lane
    import shreg_deser_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CW        = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             r_n,
    input  logic             i_valid,
    input  logic             i_bit,
    input  logic [CW-1:0]    i_cnt,
    input  logic             i_load,
`ifdef SHREG_DESER_PARITY_EN
    output logic             o_par,
`endif
    output logic [DEPTH-1:0] o_word
);

    logic [DEPTH-1:0] r_sr;
    logic [DEPTH-1:0] w_word;

    // Collected bits with the current bit already placed, so a completing word is whole
    always_comb begin
        w_word = r_sr;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (CW'(bit_pos(k, DEPTH, MSB_FIRST)) == i_cnt) begin
                w_word[k] = i_bit;
            end
        end
    end

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            r_sr   <= '0;
            o_word <= '0;
`ifdef SHREG_DESER_PARITY_EN
            o_par  <= 1'b0;
`endif
        end else begin
            if (i_valid) begin
                r_sr <= w_word;
            end
            if (i_load) begin
                o_word <= w_word;
`ifdef SHREG_DESER_PARITY_EN
                o_par  <= ^w_word;
`endif
            end
        end
    end

endmodule

// File: rtl/shreg_deser.sv
// Serial-to-parallel deserializer with a single valid/ready holding register and
// sticky overrun flag. Define SHREG_DESER_PARITY_EN to add per-lane out_par.
module shreg_deser
    import shreg_deser_pkg::*;
#(
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned DEPTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   r_n,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*DEPTH-1:0] out_data,
`ifdef SHREG_DESER_PARITY_EN
    output logic [WIDTH-1:0]       out_par,
`endif
    output logic                   overrun,
    input  logic                   ovr_clr
);

    localparam int unsigned CW = cnt_w(DEPTH);

    logic [CW-1:0] r_cnt;
    logic          w_done;
    logic          w_stall;
    logic          w_load;

    assign w_done  = in_valid && (r_cnt == CW'(DEPTH - 1));
    assign w_stall = out_valid && !out_ready;
    assign w_load  = w_done && !w_stall;

    // Bit counter, handshake and sticky overrun
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            r_cnt     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (in_valid) begin
                r_cnt <= w_done ? '0 : r_cnt + CW'(1);
            end
            if (w_load) begin
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (w_done && w_stall) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        shreg_deser_lane #(
            .DEPTH     (DEPTH),
            .MSB_FIRST (MSB_FIRST),
            .CW        (CW)
        ) u_lane (
            .clk     (clk),
            .r_n     (r_n),
            .i_valid (in_valid),
            .i_bit   (i[g]),
            .i_cnt   (r_cnt),
            .i_load  (w_load),
`ifdef SHREG_DESER_PARITY_EN
            .o_par   (out_par[g]),
`endif
            .o_word  (out_data[lane_lo(g, DEPTH) +: DEPTH])
        );
    end

endmodule

// File: tb/tb_shreg_deser.sv
// Directed bench for shreg_deser: an 8-bit MSB-first lane plus a 2-lane DEPTH=1 build.
`timescale 1ns/1ps
module tb_shreg_deser;

    logic       clk = 1'b0;
    logic       r_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [0:0] i = '0;
    logic       out_ready = 1'b1;
    logic       ovr_clr = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       overrun;

    logic       in_valid6 = 1'b0;
    logic [1:0] i6 = '0;
    logic       out_valid6;
    logic [1:0] out_data6;
    logic       overrun6;
`ifdef SHREG_DESER_PARITY_EN
    logic [0:0] out_par;
    logic [1:0] out_par6;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shreg_deser #(.WIDTH(1), .DEPTH(8), .MSB_FIRST(1'b1)) dut (
        .clk       (clk),
        .r_n       (r_n),
        .in_valid  (in_valid),
        .i         (i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef SHREG_DESER_PARITY_EN
        .out_par   (out_par),
`endif
        .overrun   (overrun),
        .ovr_clr   (ovr_clr)
    );

    shreg_deser #(.WIDTH(2), .DEPTH(1), .MSB_FIRST(1'b0)) dut6 (
        .clk       (clk),
        .r_n       (r_n),
        .in_valid  (in_valid6),
        .i         (i6),
        .out_valid (out_valid6),
        .out_ready (1'b1),
        .out_data  (out_data6),
`ifdef SHREG_DESER_PARITY_EN
        .out_par   (out_par6),
`endif
        .overrun   (overrun6),
        .ovr_clr   (1'b0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        in_valid = 1'b1;
        i[0]     = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input int gap);
        for (int k = 7; k >= 0; k--) begin
            send_bit(w[k]);
            if (k != 0) begin
                for (int g = 0; g < gap; g++) step();
            end
        end
    endtask

    initial begin
        logic [7:0] w3c;
        w3c = 8'h3C;

        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_data6", 32'(out_data6), 32'd0);
        r_n = 1'b1;
        step();

        // 1: back-to-back bits, ready high
        send_word(8'hB2, 0);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'hB2);
        step();
        chk("t1_valid_drop", 32'(out_valid), 32'd0);

        // 2: three idle cycles between bits
        send_word(8'hB2, 3);
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_data", 32'(out_data), 32'hB2);
        step();
        chk("t2_valid_drop", 32'(out_valid), 32'd0);

        // 3: backpressure drops the second word
        out_ready = 1'b0;
        send_word(8'hB2, 0);
        chk("t3_ovr_before", 32'(overrun), 32'd0);
        send_word(8'h5A, 0);
        chk("t3_hold_data", 32'(out_data), 32'hB2);
        chk("t3_hold_valid", 32'(out_valid), 32'd1);
        chk("t3_ovr_set", 32'(overrun), 32'd1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("t3_ovr_clr", 32'(overrun), 32'd0);
        chk("t3_still_held", 32'(out_data), 32'hB2);
        out_ready = 1'b1;
        step();
        chk("t3_drained", 32'(out_valid), 32'd0);

        // 4: completion coincides with transfer
        send_word(8'hB2, 0);
        out_ready = 1'b0;
        for (int k = 7; k >= 1; k--) send_bit(w3c[k]);
        chk("t4_held", 32'(out_data), 32'hB2);
        out_ready = 1'b1;
        send_bit(w3c[0]);
        chk("t4_no_bubble", 32'(out_valid), 32'd1);
        chk("t4_data", 32'(out_data), 32'h3C);
        chk("t4_no_ovr", 32'(overrun), 32'd0);
        step();
        chk("t4_drop", 32'(out_valid), 32'd0);

        // 5: async reset mid-word discards the partial word
        out_ready = 1'b0;
        send_word(8'hB2, 0);
        send_word(8'hFF, 0);
        for (int k = 0; k < 5; k++) send_bit(1'b1);
        chk("t5_pre_ovr", 32'(overrun), 32'd1);
        r_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_data", 32'(out_data), 32'd0);
        chk("t5_rst_ovr", 32'(overrun), 32'd0);
        step();
        r_n = 1'b1;
        out_ready = 1'b1;
        send_word(8'h5A, 0);
        chk("t5_fresh_valid", 32'(out_valid), 32'd1);
        chk("t5_fresh_data", 32'(out_data), 32'h5A);

        // 6: two lanes, one bit per word, LSB-first
        in_valid6 = 1'b1;
        i6 = 2'b10;
        step();
        chk("t6_valid", 32'(out_valid6), 32'd1);
        chk("t6_data", 32'(out_data6), 32'h2);
`ifdef SHREG_DESER_PARITY_EN
        chk("t6_par", 32'(out_par6), 32'h2);
`endif
        i6 = 2'b01;
        step();
        chk("t6_data_b", 32'(out_data6), 32'h1);
        chk("t6_valid_b", 32'(out_valid6), 32'd1);
        in_valid6 = 1'b0;
        step();
        chk("t6_idle", 32'(out_valid6), 32'd0);
        chk("t6_no_ovr", 32'(overrun6), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
